if_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register for the pipelined MIPS core. Owns the PC and issues requests on a ready-based instruction-memory port. Presents the fetched instruction and PC+4 to the decode stage, where instr[15:0] feeds the immediate sign extender. Honours stalls from the hazard unit and flush/redirect from branch/jump resolution.

---
 rtl/if_stage.sv | 127 ++++++++++++
 tb/tb_if_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register and a one-entry skid buffer.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
//
// state | meaning
// FLUSH | one-cycle bubble after reset or redirect, no request issued
// REQ   | requesting imem_addr=pc until imem_ready
// HOLD  | one accepted instruction buffered while decode is stalled
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {FLUSH, REQ, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, pc_plus4;
  logic [31:0] buf_instr, buf_instr_nxt, buf_pc4, buf_pc4_nxt;
  logic        id_valid_nxt;
  logic [31:0] id_instr_nxt, id_pc_plus4_nxt;
  logic        accept;
  logic [1:0]  redirect_pc_unused;

  assign redirect_pc_unused = redirect_pc[1:0];
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign accept    = imem_req & imem_ready;
  assign pc_plus4  = pc + 32'd4;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    buf_instr_nxt   = buf_instr;
    buf_pc4_nxt     = buf_pc4;
    id_valid_nxt    = id_valid;
    id_instr_nxt    = id_instr;
    id_pc_plus4_nxt = id_pc_plus4;
    if (redirect_valid) begin
      // Redirect outranks stall and accept; any word returned this cycle is dropped.
      pc_nxt          = {redirect_pc[31:2], 2'b00};
      id_valid_nxt    = 1'b0;
      id_instr_nxt    = NOP_INSTR;
      id_pc_plus4_nxt = 32'd0;
      state_nxt       = FLUSH;
    end else begin
      case (state)
        FLUSH: state_nxt = REQ;
        REQ: begin
          if (accept) begin
            pc_nxt = pc_plus4;
            if (!id_stall) begin
              id_valid_nxt    = 1'b1;
              id_instr_nxt    = imem_rdata;
              id_pc_plus4_nxt = pc_plus4;
            end else begin
              buf_instr_nxt = imem_rdata;
              buf_pc4_nxt   = pc_plus4;
              state_nxt     = HOLD;
            end
          end else if (!id_stall) begin
            id_valid_nxt = 1'b0;
            id_instr_nxt = NOP_INSTR;
          end
        end
        HOLD: begin
          if (!id_stall) begin
            id_valid_nxt    = 1'b1;
            id_instr_nxt    = buf_instr;
            id_pc_plus4_nxt = buf_pc4;
            state_nxt       = REQ;
          end
        end
        default: state_nxt = FLUSH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FLUSH;
      pc          <= RESET_PC;
      buf_instr   <= NOP_INSTR;
      buf_pc4     <= 32'd0;
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc_plus4 <= 32'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      buf_instr   <= buf_instr_nxt;
      buf_pc4     <= buf_pc4_nxt;
      id_valid    <= id_valid_nxt;
      id_instr    <= id_instr_nxt;
      id_pc_plus4 <= id_pc_plus4_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (accept && !redirect_valid)   perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (id_stall && !redirect_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then randomized traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  if_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .id_stall(id_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: pc, a bubble flag, a queue of instructions decode has not taken yet.
  logic [31:0] m_pc;
  logic        m_bubble;
  logic [63:0] m_held[$];
  logic        m_valid;
  logic [31:0] m_instr, m_pc4;
  logic [31:0] m_fetch, m_stall;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ XORK;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_0000;
    m_bubble = 1'b1;
    m_held.delete();
    m_valid = 1'b0;
    m_instr = NOP;
    m_pc4 = 32'd0;
    m_fetch = 32'd0;
    m_stall = 32'd0;
  endtask

  task automatic model_step(input logic rdy, input logic stl, input logic rv, input logic [31:0] rpc);
    logic req;
    logic [63:0] e;
    req = !m_bubble && (m_held.size() == 0);
    if (rv) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_valid = 1'b0; m_instr = NOP; m_pc4 = 32'd0;
      m_held.delete();
      m_bubble = 1'b1;
    end else begin
      if (stl) m_stall = m_stall + 1;
      if (req && rdy) m_fetch = m_fetch + 1;
      if (m_bubble) m_bubble = 1'b0;
      else if (m_held.size() != 0) begin
        if (!stl) begin
          e = m_held.pop_front();
          m_instr = e[63:32]; m_pc4 = e[31:0]; m_valid = 1'b1;
        end
      end else if (rdy) begin
        if (!stl) begin
          m_instr = mem(m_pc); m_pc4 = m_pc + 4; m_valid = 1'b1;
        end else m_held.push_back({mem(m_pc), m_pc + 32'd4});
        m_pc = m_pc + 4;
      end else if (!stl) begin
        m_valid = 1'b0; m_instr = NOP;
      end
    end
  endtask

  task automatic check_all();
    chk("imem_req", {31'd0, imem_req}, {31'd0, !m_bubble && (m_held.size() == 0)});
    chk("imem_addr", imem_addr, m_pc);
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    chk("id_instr", id_instr, m_instr);
    chk("id_pc_plus4", id_pc_plus4, m_pc4);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
    chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`else
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'd0);
    chk("perf_stall_cnt", perf_stall_cnt, 32'd0);
`endif
  endtask

  // Called at a falling edge: drive inputs, cross the rising edge, check at the next falling edge.
  task automatic step(input logic rdy, input logic stl, input logic rv, input logic [31:0] rpc);
    imem_ready = rdy;
    id_stall = stl;
    redirect_valid = rv;
    redirect_pc = rpc;
    imem_rdata = rdy ? mem(imem_addr) : $urandom;
    @(posedge clk);
    model_step(rdy, stl, rv, rpc);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    imem_ready = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; imem_rdata = 32'd0;
    rst_n = 1'b1;
    @(negedge clk);
    do_reset();
    chk("reset_id_instr", id_instr, NOP);

    // Stream from reset with memory always ready.
    step(1, 0, 0, 0);
    chk("first_addr", imem_addr, 32'h0);
    step(1, 0, 0, 0);
    chk("first_pc4", id_pc_plus4, 32'h4);
    step(1, 0, 0, 0);
    // Memory not ready for three cycles on address 8.
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("wait_addr", imem_addr, 32'h8);
    step(1, 0, 0, 0);
    chk("after_wait_pc4", id_pc_plus4, 32'hC);
    step(1, 0, 0, 0);
    // Stall for four cycles while address 16 is accepted.
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    step(1, 0, 0, 0);
    chk("release_instr", id_instr, mem(32'h10));
    chk("release_addr", imem_addr, 32'h14);
    step(1, 0, 0, 0);
    // Redirect with stall and accept in the same cycle.
    step(1, 1, 1, 32'h0000_0103);
    chk("redir_valid", {31'd0, id_valid}, 32'd0);
    step(1, 0, 0, 0);
    chk("redir_addr", imem_addr, 32'h100);
    step(1, 0, 0, 0);
    // Redirect to the top of the address space and wrap.
    step(1, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("wrap_pc4", id_pc_plus4, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset in the middle of an outstanding request.
    step(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
